// File: rtl/olivia_fetch_queue.sv
`default_nettype none
// olivia_fetch_queue: LEGv8 fetch front end with a DEPTH-entry prefetch queue,
// credit-limited in-order imem requests and redirect flush.  Rev 1.0
module olivia_fetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDR_W-1:0]        imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [INSTR_W-1:0]       imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]   out_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  rsp_pc;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   drop_cnt;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  logic [CNT_W:0]     credit_used;
  logic               req_fire;
  logic               rsp_take;
  logic               push;
  logic               drop;
  logic               pop;
  logic [ADDR_W-1:0]  redirect_base;
  logic [CNT_W-1:0]   inflight_after_rsp;

  // Queued entries plus outstanding requests never exceed DEPTH, so a kept
  // response always finds a free slot.
  assign credit_used    = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = RST && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take           = imem_rsp_valid && (inflight != '0);
  assign push               = rsp_take && !redirect_valid && (drop_cnt == '0);
  assign drop               = rsp_take && !redirect_valid && (drop_cnt != '0);
  assign inflight_after_rsp = inflight - CNT_W'(rsp_take);
  assign redirect_base      = redirect_pc & ~ADDR_W'(3);

  assign out_valid = RST && (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_level = RST ? count : '0;
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding belongs to the old stream.
      fetch_pc <= redirect_base;
      rsp_pc   <= redirect_base;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= inflight_after_rsp;
      drop_cnt <= inflight_after_rsp;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
      inflight <= inflight_after_rsp + CNT_W'(req_fire);
      if (drop) drop_cnt <= drop_cnt - CNT_W'(1);
      if (push) begin
        rsp_pc <= rsp_pc + ADDR_W'(4);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && push) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && imem_rsp_valid) assert (inflight != '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_olivia_fetch_queue.sv
`default_nettype none
// tb_olivia_fetch_queue: directed stimulus with a scoreboard queue of expected
// outputs and a latency-configurable instruction memory returning word = addr.
module tb_olivia_fetch_queue;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  out_level;

  logic        d2_req_valid, d2_out_valid;
  logic [63:0] d2_req_addr, d2_out_pc;
  logic [31:0] d2_out_instr;
  logic [2:0]  d2_out_level;

  always #5 CLK = ~CLK;

  olivia_fetch_queue dut (
    .CLK(CLK), .RST(RST),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_level(out_level)
  );

  // Second instance only exercises a non-zero RESET_PC near the top of memory.
  olivia_fetch_queue #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut2 (
    .CLK(CLK), .RST(RST),
    .imem_req_valid(d2_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(d2_req_addr), .imem_rsp_valid(1'b0),
    .imem_rsp_data(32'h0), .redirect_valid(1'b0),
    .redirect_pc(64'h0), .out_valid(d2_out_valid), .out_ready(1'b0),
    .out_instr(d2_out_instr), .out_pc(d2_out_pc), .out_level(d2_out_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory model: in-order, fixed latency per phase, word = low 32 bits of addr.
  typedef struct { logic [63:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [63:0] req_log[$];
  int          cyc = 0;
  int          lat = 1;

  initial forever begin
    @(posedge CLK);
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].addr[31:0];
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (imem_req_valid && imem_req_ready) begin
      pend.push_back('{imem_req_addr, cyc + lat});
      req_log.push_back(imem_req_addr);
    end
  end

  // Scoreboard
  typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic [63:0] pc);
    exp_q.push_back('{pc, pc[31:0]});
  endtask

  initial forever begin
    @(negedge CLK);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output pc=%0h instr=%0h with no expected entry", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", {32'h0, out_instr}, {32'h0, e.instr});
      end
    end
  end

  // Non-zero RESET_PC: first three requests after the first release.
  initial begin
    @(posedge RST);
    @(negedge CLK); chk("d2_addr0", {63'h0, d2_req_valid} << 0 == 1 ? d2_req_addr : 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFF8);
    @(negedge CLK); chk("d2_addr1", d2_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge CLK); chk("d2_addr2", d2_req_addr, 64'h0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Consume n outputs; start at posedge+1 (or while out_ready is already 1).
  task automatic consume(input int n, output int first, output int last);
    int got = 0;
    int idx = 0;
    first = -1;
    last  = -1;
    out_ready = 1'b1;
    while (got < n && idx < 200) begin
      @(negedge CLK);
      if (out_valid && out_ready) begin
        got++;
        if (first < 0) first = idx;
        last = idx;
      end
      idx++;
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL consume_timeout got=%0d required=%0d", got, n);
    end
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic reset_enter();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_level", {61'h0, out_level}, 64'h0);
    repeat (8) @(posedge CLK);
  endtask

  // Called at a rising edge; releases reset 1 time unit later.
  task automatic release_rst(input int l, input logic rr, input logic ordy);
    #1;
    lat            = l;
    imem_req_ready = rr;
    out_ready      = ordy;
    RST            = 1'b1;
    req_log.delete();
  endtask

  initial begin
    int f, l;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("init_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("init_out_valid", {63'h0, out_valid}, 64'h0);
    chk("init_out_level", {61'h0, out_level}, 64'h0);
    @(posedge CLK);

    // Streaming with 1-cycle memory
    release_rst(1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) push_exp(64'(4 * i));
    @(negedge CLK);
    chk("t1_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("t1_req_addr", imem_req_addr, 64'h0);
    chk("t1_out_valid_early", {63'h0, out_valid}, 64'h0);
    consume(8, f, l);
    chk("t1_first_out_cycle", 64'(f), 64'd1);
    chk("t1_gapless_span", 64'(l - f), 64'd7);

    // Back-pressure: queue fills after exactly four requests
    reset_enter();
    release_rst(1, 1'b1, 1'b0);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    chk("t2_num_req", 64'(req_log.size()), 64'd4);
    for (int i = 0; i < req_log.size() && i < 4; i++) chk("t2_req_addr", req_log[i], 64'(4 * i));
    chk("t2_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("t2_level_full", {61'h0, out_level}, 64'd4);
    for (int i = 0; i < 6; i++) push_exp(64'(4 * i));
    @(posedge CLK); #1;
    consume(6, f, l);
    chk("t2_resume_addr", req_log.size() > 4 ? req_log[4] : 64'hDEAD, 64'h10);

    // Back-to-back redirects with 3-cycle memory, unaligned target
    reset_enter();
    release_rst(3, 1'b1, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80;
    @(negedge CLK);
    chk("t3_req_blocked", {63'h0, imem_req_valid}, 64'h0);
    chk("t3_inflight_req", 64'(req_log.size()), 64'd2);
    @(posedge CLK); #1;
    redirect_pc = 64'h43;
    @(posedge CLK); #1;
    redirect_valid = 1'b0;
    @(negedge CLK);
    chk("t3_req_addr", imem_req_addr, 64'h40);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("t3_level_after_drop", {61'h0, out_level}, 64'h0);
    push_exp(64'h40); push_exp(64'h44); push_exp(64'h48);
    @(posedge CLK); #1;
    consume(3, f, l);

    // Redirect near top of address space, wrap to 0
    reset_enter();
    release_rst(1, 1'b1, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
    @(posedge CLK); #1;
    redirect_valid = 1'b0;
    @(negedge CLK);
    chk("t4_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("t4_flushed", {61'h0, out_level}, 64'h0);
    push_exp(64'hFFFF_FFFF_FFFF_FFF8); push_exp(64'hFFFF_FFFF_FFFF_FFFC);
    push_exp(64'h0); push_exp(64'h4);
    @(posedge CLK); #1;
    consume(4, f, l);

    // Request stall, then simultaneous push and pop
    reset_enter();
    release_rst(1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("t5_stall_valid", {63'h0, imem_req_valid}, 64'h1);
      chk("t5_stall_addr", imem_req_addr, 64'h0);
    end
    chk("t5_no_handshake", 64'(req_log.size()), 64'd0);
    @(posedge CLK); #1;
    imem_req_ready = 1'b1;
    push_exp(64'h0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("t5_level_before", {61'h0, out_level}, 64'd1);
    @(posedge CLK); #1;
    out_ready = 1'b0;
    @(negedge CLK);
    chk("t5_level_after", {61'h0, out_level}, 64'd1);
    for (int i = 1; i < 5; i++) push_exp(64'(4 * i));
    @(posedge CLK); #1;
    consume(4, f, l);

    // Reset mid-operation with requests outstanding
    reset_enter();
    release_rst(3, 1'b1, 1'b0);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("t6_level_pre", {61'h0, out_level}, 64'd1);
    reset_enter();
    release_rst(1, 1'b1, 1'b0);
    @(negedge CLK);
    chk("t6_restart_addr", imem_req_addr, 64'h0);
    push_exp(64'h0); push_exp(64'h4); push_exp(64'h8);
    @(posedge CLK); #1;
    consume(3, f, l);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
